ctrl_fsm_param: RTL
===================

// Module: ctrl_fsm_param
// PURPOSE
// - Parametrised control FSM for the 16-bit datapath: sequences fetch/decode/execute and drives PC, IR, data memory, register file and ALU selects.
// - Adds over the prior controller: generic field widths, memory ready handshake on LOAD/STORE, HALT resume, retired-instruction counter, optional branch ops.
// - Sits between instruction memory/PC and the datapath; all control outputs are combinational from state and IR.
// PARAMETERS
// - REG_AW   4   register-file address width; Ra=IR[3*REG_AW-1:2*REG_AW], Rb=IR[2*REG_AW-1:REG_AW], Rw=IR[REG_AW-1:0]
// - DATA_AW  8   data-memory address width; LOAD addr=IR[DATA_AW+REG_AW-1:REG_AW], STORE addr=IR[DATA_AW-1:0]
// - PC_W     7   program-counter width; branch target=IR[PC_W-1:0]
// - CNT_W    16  retired-instruction counter width
// - IR_W = 4+DATA_AW+REG_AW (derived, 16 at defaults); opcode=IR[IR_W-1:IR_W-4]; require 3*REG_AW<=IR_W-4, PC_W<=IR_W-4-REG_AW
// PORTS
// - clk         in   1        rising-edge clock
// - Reset       in   1        asynchronous, active-low reset
// - IR          in   IR_W     instruction register contents
// - mem_ready   in   1        data memory accepted/returned the current access
// - resume      in   1        leave HALT (sampled only in HALT)
// - alu_zero    in   1        ALU result==0 (used by JZ)
// - PC_clr, PC_up, PC_ld, IR_ld  out 1  PC clear / increment / load target, IR load
// - PC_target   out  PC_W     branch target
// - D_addr      out  DATA_AW  data-memory address
// - D_wr        out  1        data-memory write strobe
// - RF_s        out  1        RF write source: 1=memory, 0=ALU
// - RF_W_en     out  1        RF write enable
// - RF_W_addr, RF_Ra_addr, RF_Rb_addr  out REG_AW  RF addresses
// - ALU_s       out  3        000 pass A, 001 add, 010 sub
// - state       out  4        current state encoding
// - halted      out  1        1 while in HALT
// - retire_cnt  out  CNT_W    retired-instruction count
// BEHAVIOUR
// - States: INIT=0 FETCH=1 DECODE=2 NOOP=3 LOAD_A=4 LOAD_B=5 STORE=6 ADD=7 HALT=8 SUB=9 JUMP=A; B-F -> INIT.
// - Reset low: state=INIT, retire_cnt=0 immediately (async), regardless of in-flight access; outputs = INIT decode (PC_clr=1, all else 0).
// - Unlisted outputs default 0 in every state.
// - INIT: PC_clr=1 -> FETCH.  FETCH: PC_up=1, IR_ld=1 -> DECODE.
// - DECODE opcode: 1 STORE, 2 LOAD_A, 3 ADD, 4 SUB, 5 HALT, 6/7 JUMP (macro only), else NOOP.
// - NOOP -> FETCH.  ADD/SUB: Ra,Rb,Rw from IR, RF_W_en=1, ALU_s=001/010, RF_s=0 -> FETCH (1 cycle).
// - LOAD_A: D_addr, RF_s=1, RF_W_addr driven; holds until mem_ready=1, then -> LOAD_B. LOAD_B: same + RF_W_en=1 -> FETCH.
// - STORE: D_addr, RF_Ra_addr=IR[11:8]-field, D_wr=1 held every cycle until mem_ready=1 -> FETCH.
// - HALT: halted=1; resume=1 -> FETCH (PC not cleared), else stay. resume ignored in all other states.
// - retire_cnt +1 on the exit cycle of NOOP, LOAD_B, STORE(with mem_ready), ADD, SUB, JUMP; HALT not counted; saturates at all-ones.
// - Instruction latency: 3 cycles fetch/decode/exec; LOAD 4+wait, STORE 3+wait.
// CONFIGURATION
// - CTRL_BRANCH_EN defined: opcode 6 JMP, 7 JZ -> JUMP state: RF_Ra_addr=Ra field, ALU_s=000, PC_target=IR[PC_W-1:0], PC_ld=1 for JMP, PC_ld=alu_zero for JZ -> FETCH.
// - Undefined: opcodes 6/7 decode to NOOP; JUMP unreachable; PC_ld=0, PC_target=0 constant.
// TESTING
// - Reset low mid-STORE wait (D_wr=1) -> same cycle state=0, D_wr=0, PC_clr=1, retire_cnt=0; release -> FETCH next edge.
// - IR=16'h3124 -> DECODE then ADD: Ra=1 Rb=2 Rw=4 W_en=1 ALU_s=001; retire_cnt=1; FETCH next.
// - IR=16'h2AB3, mem_ready low 3 cycles -> LOAD_A held 4 cycles D_addr=8'hAB RF_W_en=0; LOAD_B W_en=1 Rw=3.
// - IR=16'h5000 -> HALT, halted=1 for 10 cycles with count frozen; resume pulse -> FETCH, PC_clr=0.
// - retire_cnt preloaded via CNT_W=4 and 16 NOOPs -> holds 4'hF, no wrap.
// - CTRL_BRANCH_EN: IR=16'h7205, alu_zero=1 -> PC_ld=1 PC_target=5; alu_zero=0 -> PC_ld=0; undefined: 16'h6005 -> NOOP.

Source files
------------

// File: rtl/ctrl_fsm_param_if.sv
// Control bundle between the fetch/decode/execute controller and the 16-bit datapath.
// master = controller (drives PC/IR/memory/RF/ALU selects), slave = datapath side.
interface ctrl_fsm_param_if #(
  parameter int REG_AW  = 4,
  parameter int DATA_AW = 8,
  parameter int PC_W    = 7,
  parameter int CNT_W   = 16
);
  localparam int IR_W = 4 + DATA_AW + REG_AW;

  logic [IR_W-1:0]    ir;
  logic               mem_ready;
  logic               resume;
  logic               alu_zero;

  logic               pc_clr;
  logic               pc_up;
  logic               pc_ld;
  logic               ir_ld;
  logic [PC_W-1:0]    pc_target;
  logic [DATA_AW-1:0] d_addr;
  logic               d_wr;
  logic               rf_s;
  logic               rf_w_en;
  logic [REG_AW-1:0]  rf_w_addr;
  logic [REG_AW-1:0]  rf_ra_addr;
  logic [REG_AW-1:0]  rf_rb_addr;
  logic [2:0]         alu_s;
  logic [3:0]         state;
  logic               halted;
  logic [CNT_W-1:0]   retire_cnt;

  modport master (
    input  ir, mem_ready, resume, alu_zero,
    output pc_clr, pc_up, pc_ld, ir_ld, pc_target, d_addr, d_wr, rf_s, rf_w_en,
           rf_w_addr, rf_ra_addr, rf_rb_addr, alu_s, state, halted, retire_cnt
  );

  modport slave (
    output ir, mem_ready, resume, alu_zero,
    input  pc_clr, pc_up, pc_ld, ir_ld, pc_target, d_addr, d_wr, rf_s, rf_w_en,
           rf_w_addr, rf_ra_addr, rf_rb_addr, alu_s, state, halted, retire_cnt
  );
endinterface

// File: rtl/ctrl_fsm_param.sv
// Fetch/decode/execute controller; 3 cycles per instruction, LOAD 4 / STORE 3 plus mem_ready wait,
// HALT parks until resume. Define CTRL_BRANCH_EN to enable opcode 6 JMP / 7 JZ via the JUMP state.
module ctrl_fsm_param #(
  parameter int REG_AW  = 4,
  parameter int DATA_AW = 8,
  parameter int PC_W    = 7,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  ctrl_fsm_param_if.master bus
);
  localparam int IR_W = 4 + DATA_AW + REG_AW;

  typedef enum logic [3:0] {
    S_INIT   = 4'h0,
    S_FETCH  = 4'h1,
    S_DECODE = 4'h2,
    S_NOOP   = 4'h3,
    S_LOAD_A = 4'h4,
    S_LOAD_B = 4'h5,
    S_STORE  = 4'h6,
    S_ADD    = 4'h7,
    S_HALT   = 4'h8,
    S_SUB    = 4'h9,
    S_JUMP   = 4'hA
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               retire;

  logic [3:0]         opcode;
  logic [REG_AW-1:0]  ra_fld;
  logic [REG_AW-1:0]  rb_fld;
  logic [REG_AW-1:0]  rw_fld;
  logic [DATA_AW-1:0] ld_addr;
  logic [DATA_AW-1:0] st_addr;

  assign opcode  = bus.ir[IR_W-1 -: 4];
  assign ra_fld  = bus.ir[3*REG_AW-1 -: REG_AW];
  assign rb_fld  = bus.ir[2*REG_AW-1 -: REG_AW];
  assign rw_fld  = bus.ir[REG_AW-1:0];
  assign ld_addr = bus.ir[DATA_AW+REG_AW-1 -: DATA_AW];
  assign st_addr = bus.ir[DATA_AW-1:0];

  // An instruction retires on its last execute cycle; HALT never counts.
  assign retire = (state_q == S_NOOP) || (state_q == S_LOAD_B) || (state_q == S_ADD) ||
                  (state_q == S_SUB)  || (state_q == S_JUMP) ||
                  ((state_q == S_STORE) && bus.mem_ready);
  assign cnt_d  = (retire && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        S_INIT:   state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            4'd1:    state_q <= S_STORE;
            4'd2:    state_q <= S_LOAD_A;
            4'd3:    state_q <= S_ADD;
            4'd4:    state_q <= S_SUB;
            4'd5:    state_q <= S_HALT;
`ifdef CTRL_BRANCH_EN
            4'd6,
            4'd7:    state_q <= S_JUMP;
`endif
            default: state_q <= S_NOOP;
          endcase
        end
        S_LOAD_A: state_q <= bus.mem_ready ? S_LOAD_B : S_LOAD_A;
        S_STORE:  state_q <= bus.mem_ready ? S_FETCH : S_STORE;
        S_HALT:   state_q <= bus.resume ? S_FETCH : S_HALT;
        S_NOOP, S_LOAD_B, S_ADD, S_SUB, S_JUMP:
                  state_q <= S_FETCH;
        default:  state_q <= S_INIT;
      endcase
    end
  end

  always_comb begin
    bus.pc_clr     = 1'b0;
    bus.pc_up      = 1'b0;
    bus.pc_ld      = 1'b0;
    bus.ir_ld      = 1'b0;
    bus.pc_target  = '0;
    bus.d_addr     = '0;
    bus.d_wr       = 1'b0;
    bus.rf_s       = 1'b0;
    bus.rf_w_en    = 1'b0;
    bus.rf_w_addr  = '0;
    bus.rf_ra_addr = '0;
    bus.rf_rb_addr = '0;
    bus.alu_s      = 3'b000;
    bus.halted     = 1'b0;
    case (state_q)
      S_INIT:  bus.pc_clr = 1'b1;
      S_FETCH: begin
        bus.pc_up = 1'b1;
        bus.ir_ld = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        bus.d_addr    = ld_addr;
        bus.rf_s      = 1'b1;
        bus.rf_w_addr = rw_fld;
        bus.rf_w_en   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        bus.d_addr     = st_addr;
        bus.rf_ra_addr = ra_fld;
        bus.d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.rf_ra_addr = ra_fld;
        bus.rf_rb_addr = rb_fld;
        bus.rf_w_addr  = rw_fld;
        bus.rf_w_en    = 1'b1;
        bus.alu_s      = (state_q == S_ADD) ? 3'b001 : 3'b010;
      end
      S_HALT:  bus.halted = 1'b1;
`ifdef CTRL_BRANCH_EN
      // ALU passes Ra so alu_zero reflects the tested register for JZ.
      S_JUMP: begin
        bus.rf_ra_addr = ra_fld;
        bus.alu_s      = 3'b000;
        bus.pc_target  = bus.ir[PC_W-1:0];
        bus.pc_ld      = (opcode == 4'd7) ? bus.alu_zero : 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifndef CTRL_BRANCH_EN
  logic unused_alu_zero;
  assign unused_alu_zero = bus.alu_zero;
`endif

  assign bus.state      = state_q;
  assign bus.retire_cnt = cnt_q;
endmodule
